lcd_snoop: RTL

- Passive listener on the LCD module bus driven by the original mainboard CPU. It is the receiving end of the 10-chip, 50x32-per-chip LCD bus.
- Decodes instructions and data writes exactly as the LCD chips would, and tracks per-chip page/column/mode state.
- Emits one framebuffer write per captured pixel byte, in 240x8-row screen coordinates, so the host framebuffer mirrors the physical panel.

---
 rtl/lcd_snoop_if.sv | 32 +++
 rtl/lcd_snoop.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_snoop_if.sv
// lcd_snoop_if -- LCD module bus as seen by the snoop.
//
// Purpose: bundles the mainboard-to-LCD bus so the snoop and its driver share
// one port.
//
// Signals:
//   data_pin    [7:0]             data bus
//   cs_pin      [LCD_MODULES-1:0] per-chip selects, active high
//   cs1_pin                       global chip enable, active high
//   di_pin                        1 = data, 0 = instruction
//   enable_pin                    bus strobe
//
// Transfer semantics: there is no valid/ready pair. The bus is fire-and-forget:
// the driver holds data_pin/di_pin/cs_pin/cs1_pin stable for at least 3 clk
// cycles, then raises enable_pin. The rising edge of enable_pin is the transfer
// and the listener has no way to stall it. A transfer is taken only while
// cs1_pin is high.
//
// Modports: master = bus driver (mainboard CPU or testbench), slave = snoop.

interface lcd_snoop_if #(
  parameter int LCD_MODULES = 10
);
  logic [7:0]             data_pin;
  logic [LCD_MODULES-1:0] cs_pin;
  logic                   cs1_pin;
  logic                   di_pin;
  logic                   enable_pin;

  modport master (output data_pin, cs_pin, cs1_pin, di_pin, enable_pin);
  modport slave  (input  data_pin, cs_pin, cs1_pin, di_pin, enable_pin);
endinterface

// File: rtl/lcd_snoop.sv
// lcd_snoop -- passive listener on the multi-chip LCD module bus.
//
// Purpose: decodes instruction and data writes the same way the LCD chips do.
// It tracks page, column and mode for every chip, and emits one framebuffer
// write per captured pixel byte in 240 x 8-row screen coordinates.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   bus        in   lcd_snoop_if.slave (data/cs/cs1/di/enable pins)
//   fb_x       out  screen column 0..MAX_X-1 (0 when fb_we is low)
//   fb_y       out  screen row of 8 pixels 0..7 (0 when fb_we is low)
//   fb_data    out  pixel byte (0 when fb_we is low)
//   fb_we      out  one-cycle framebuffer write strobe
//   disp_on    out  per-chip display-on flags
//   overrun    out  sticky; set when a strobe arrives while a transfer is in progress
//   dbg_state  out  current FSM state (state_t encoding)
//
// Configuration macro: LCD_SNOOP_SCROLL_EN
//   defined   -> per-chip start-line register; instruction 0x3E loads it;
//                fb_y row = (page - start) mod 4
//   undefined -> no start register; 0x3E is ignored; fb_y row = page

module lcd_snoop #(
  parameter int LCD_MODULES  = 10,
  parameter int X_PER_MODULE = 50,
  parameter int MAX_X        = 240
) (
  input  logic                   clk,
  input  logic                   reset_n,
  lcd_snoop_if.slave             bus,
  output logic [7:0]             fb_x,
  output logic [2:0]             fb_y,
  output logic [7:0]             fb_data,
  output logic                   fb_we,
  output logic [LCD_MODULES-1:0] disp_on,
  output logic                   overrun,
  output logic [1:0]             dbg_state
);

  localparam int         HALF    = LCD_MODULES / 2;
  localparam int         IDX_W   = $clog2(LCD_MODULES);
  localparam logic [5:0] COL_MAX = 6'(X_PER_MODULE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Two-flop synchronizers for every bus input.
  // A third enable flop provides the edge detector.
  logic [7:0]             r_data_s1, r_data_s2;
  logic [LCD_MODULES-1:0] r_cs_s1, r_cs_s2;
  logic                   r_cs1_s1, r_cs1_s2;
  logic                   r_di_s1, r_di_s2;
  logic                   r_en_s1, r_en_s2, r_en_s3;

  // Values latched at the strobe.
  logic [7:0]             r_lat_data;
  logic                   r_lat_di;
  logic [LCD_MODULES-1:0] r_lat_cs;

  // Chips that still owe a framebuffer write for the latched byte.
  logic [LCD_MODULES-1:0] r_pending;
  logic [LCD_MODULES-1:0] w_pending_after;

  // Per-chip state.
  logic [1:0]             r_page [LCD_MODULES];
  logic [5:0]             r_col  [LCD_MODULES];
  logic                   r_up   [LCD_MODULES];
`ifdef LCD_SNOOP_SCROLL_EN
  logic [1:0]             r_start [LCD_MODULES];
`endif
  logic [LCD_MODULES-1:0] r_disp_on;
  logic                   r_overrun;

  logic                   w_strobe;
  logic [IDX_W-1:0]       w_sel_idx;
  logic [LCD_MODULES-1:0] w_sel_onehot;
  logic                   w_upper;
  logic [IDX_W-1:0]       w_mod;
  logic [5:0]             w_col;
  logic [5:0]             w_col_next;
  logic [1:0]             w_row;
  logic [8:0]             w_x_full;
  logic                   w_in_range;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_s1 <= '0;
      r_data_s2 <= '0;
      r_cs_s1   <= '0;
      r_cs_s2   <= '0;
      r_cs1_s1  <= 1'b0;
      r_cs1_s2  <= 1'b0;
      r_di_s1   <= 1'b0;
      r_di_s2   <= 1'b0;
      r_en_s1   <= 1'b0;
      r_en_s2   <= 1'b0;
      r_en_s3   <= 1'b0;
    end else begin
      r_data_s1 <= bus.data_pin;
      r_data_s2 <= r_data_s1;
      r_cs_s1   <= bus.cs_pin;
      r_cs_s2   <= r_cs_s1;
      r_cs1_s1  <= bus.cs1_pin;
      r_cs1_s2  <= r_cs1_s1;
      r_di_s1   <= bus.di_pin;
      r_di_s2   <= r_di_s1;
      r_en_s1   <= bus.enable_pin;
      r_en_s2   <= r_en_s1;
      r_en_s3   <= r_en_s2;
    end
  end

  // A strobe with cs1 low does not exist for this chip set.
  // It is neither taken nor counted as an overrun.
  assign w_strobe = r_en_s2 & ~r_en_s3 & r_cs1_s2;

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_strobe) w_next = S_DECODE;
      // A data byte to no selected chip has nothing to drain.
      S_DECODE: w_next = (r_lat_di && (r_lat_cs != '0)) ? S_DRAIN : S_IDLE;
      S_DRAIN:  if (w_pending_after == '0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Strobe capture, pending mask, overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_data <= '0;
      r_lat_di   <= 1'b0;
      r_lat_cs   <= '0;
      r_pending  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_strobe) begin
        r_lat_data <= r_data_s2;
        r_lat_di   <= r_di_s2;
        r_lat_cs   <= r_cs_s2;
      end
      // A strobe outside IDLE is dropped; the drain in progress still completes.
      if (r_state != S_IDLE && w_strobe) r_overrun <= 1'b1;
      if (r_state == S_DECODE && r_lat_di) r_pending <= r_lat_cs;
      else if (r_state == S_DRAIN)         r_pending <= w_pending_after;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain selection: lowest-index pending chip
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_idx = '0;
    for (int i = LCD_MODULES - 1; i >= 0; i--) begin
      if (r_pending[i]) w_sel_idx = IDX_W'(i);
    end
  end

  assign w_sel_onehot    = LCD_MODULES'(1) << w_sel_idx;
  assign w_pending_after = r_pending & ~w_sel_onehot;

  // Chips HALF.. drive the lower half of the panel and reuse the upper half's x.
  assign w_upper = (w_sel_idx >= IDX_W'(HALF));
  assign w_mod   = w_upper ? (w_sel_idx - IDX_W'(HALF)) : w_sel_idx;
  assign w_col   = r_col[w_sel_idx];

  // Computed at 9 bits so columns past the 240-wide screen are detected.
  // The rightmost chip pair covers x = 200..249.
  assign w_x_full   = (9'(w_mod) * 9'(X_PER_MODULE)) + 9'(w_col);
  assign w_in_range = (w_x_full < 9'(MAX_X));

`ifdef LCD_SNOOP_SCROLL_EN
  // 2-bit subtraction wraps mod 4, matching the chip's start-line scroll.
  assign w_row = r_page[w_sel_idx] - r_start[w_sel_idx];
`else
  assign w_row = r_page[w_sel_idx];
`endif

  // Column auto-advance: wraps at the chip edge in either direction.
  always_comb begin
    w_col_next = w_col;
    if (r_up[w_sel_idx]) w_col_next = (w_col == COL_MAX) ? 6'd0 : (w_col + 6'd1);
    else                 w_col_next = (w_col == 6'd0) ? COL_MAX : (w_col - 6'd1);
  end

  // Outputs are decoded straight from registered state, so the first write
  // appears in the first DRAIN cycle. An asynchronous reset clears them at once.
  always_comb begin
    fb_we   = 1'b0;
    fb_x    = '0;
    fb_y    = '0;
    fb_data = '0;
    if (r_state == S_DRAIN && w_in_range) begin
      fb_we   = 1'b1;
      fb_x    = w_x_full[7:0];
      fb_y    = {w_upper, w_row};
      fb_data = r_lat_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-chip state: instructions in DECODE, column advance in DRAIN
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LCD_MODULES; i++) begin
        r_page[i]  <= 2'd0;
        r_col[i]   <= 6'd0;
        r_up[i]    <= 1'b1;
`ifdef LCD_SNOOP_SCROLL_EN
        r_start[i] <= 2'd0;
`endif
      end
      r_disp_on <= '0;
    end else if (r_state == S_DECODE && !r_lat_di) begin
      for (int i = 0; i < LCD_MODULES; i++) begin
        if (r_lat_cs[i]) begin
          if (r_lat_data[5:0] < 6'(X_PER_MODULE)) begin
            r_page[i] <= r_lat_data[7:6];
            r_col[i]  <= r_lat_data[5:0];
          end else begin
            case (r_lat_data[5:0])
              6'h39:   r_disp_on[i] <= 1'b1;
              6'h38:   r_disp_on[i] <= 1'b0;
              6'h3B:   r_up[i]      <= 1'b1;
              6'h3A:   r_up[i]      <= 1'b0;
`ifdef LCD_SNOOP_SCROLL_EN
              6'h3E:   r_start[i]   <= r_lat_data[7:6];
`endif
              default: ;
            endcase
          end
        end
      end
    end else if (r_state == S_DRAIN) begin
      // The column advances even when the write itself is dropped off-screen.
      r_col[w_sel_idx] <= w_col_next;
    end
  end

  assign disp_on = r_disp_on;
  assign overrun = r_overrun;

endmodule
